fhg_axis_pkt_gen: RTL and testbench

Fixed-format AXI4-Stream packet generator that sits directly upstream of fhg_axis_adapter and drives its casper_tx_* input at 1024 bits per beat. Produces runtime-configurable packet length, packet count and inter-packet gap, with a deterministic, self-checking payload. Used in bring-up and loopback tests of the 400G DCMAC path.

---
 rtl/fhg_axis_pkt_gen.sv | 152 +++++++++++++++
 tb/tb_fhg_axis_pkt_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fhg_axis_pkt_gen.sv
// AXI4-Stream packet generator: configurable length/count/gap, self-describing payload.
// Optional error injection on tuser enabled by defining FHG_PKT_GEN_ERR_INJ_EN.
module fhg_axis_pkt_gen #(
  parameter int DATA_WIDTH    = 1024,
  parameter int MIN_PKT_BYTES = 64,
  parameter int MAX_PKT_BYTES = 9600
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             cfg_pkt_bytes,
  input  logic [7:0]              cfg_gap,
  input  logic [31:0]             cfg_num_pkts,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
`ifdef FHG_PKT_GEN_ERR_INJ_EN
  input  logic                    err_inj,
`endif
  output logic                    busy,
  output logic [31:0]             pkt_cnt
);
  localparam int KEEP_W    = DATA_WIDTH / 8;
  localparam int NUM_LANES = DATA_WIDTH / 64;
  localparam int REM_W     = $clog2(KEEP_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_nxt;

  logic [15:0]      beats_q, beats_d, beat_q, beat_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [7:0]       gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [31:0]      num_q, num_d, seq_q, seq_d, cnt_d;
  logic [15:0]      len_clamp, beats_in;
  logic             accept, hs, last_hs, done, last_d;
  logic                  tvalid_d, tlast_d, tuser_d, busy_d;
  logic [KEEP_W-1:0]     tkeep_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [NUM_LANES-1:0][63:0] lane_data;

  assign len_clamp = (cfg_pkt_bytes < 16'(MIN_PKT_BYTES)) ? 16'(MIN_PKT_BYTES) :
                     (cfg_pkt_bytes > 16'(MAX_PKT_BYTES)) ? 16'(MAX_PKT_BYTES) : cfg_pkt_bytes;
  assign beats_in  = 16'((32'(len_clamp) + 32'(KEEP_W - 1)) / 32'(KEEP_W));
  assign accept    = (state == IDLE) && start && !stop;
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_hs   = hs && m_axis_tlast;
  assign done      = (num_q != 32'd0) && (pkt_cnt + 32'd1 == num_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: if (last_hs) begin
        if (done || stop)     state_nxt = IDLE;
        else if (gap_q != '0) state_nxt = GAP;
        else                  state_nxt = SEND;
      end
      GAP: begin
        if (stop)                   state_nxt = IDLE;
        else if (gap_cnt_q == 8'd1) state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the beat to be presented next cycle; held across stalls.
  always_comb begin
    beats_d   = beats_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    num_d     = num_q;
    seq_d     = seq_q;
    beat_d    = beat_q;
    cnt_d     = pkt_cnt;
    gap_cnt_d = gap_cnt_q;
    if (accept) begin
      beats_d = beats_in;
      rem_d   = len_clamp[REM_W-1:0];
      gap_d   = cfg_gap;
      num_d   = cfg_num_pkts;
      seq_d   = '0;
      beat_d  = '0;
      cnt_d   = '0;
    end
    if (state == SEND && hs) begin
      if (m_axis_tlast) begin
        seq_d     = seq_q + 32'd1;
        beat_d    = '0;
        cnt_d     = pkt_cnt + 32'd1;
        gap_cnt_d = gap_q;
      end else begin
        beat_d = beat_q + 16'd1;
      end
    end
    if (state == GAP) gap_cnt_d = gap_cnt_q - 8'd1;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_data[k] = {seq_d, beat_d, 16'(k)};
  end

`ifdef FHG_PKT_GEN_ERR_INJ_EN
  logic err_arm_q, err_arm_d;
`endif

  always_comb begin
    last_d   = (beat_d == beats_d - 16'd1);
    tvalid_d = (state_nxt == SEND);
    tlast_d  = tvalid_d && last_d;
    busy_d   = (state_nxt != IDLE);
    tdata_d  = tvalid_d ? lane_data : '0;
    tkeep_d  = '0;
    if (tvalid_d)
      tkeep_d = (last_d && rem_d != '0) ? ~({KEEP_W{1'b1}} << rem_d) : {KEEP_W{1'b1}};
`ifdef FHG_PKT_GEN_ERR_INJ_EN
    // A pulse landing on a tlast beat re-arms for the following packet.
    err_arm_d = (err_arm_q && !(last_hs && m_axis_tuser)) || err_inj;
    tuser_d   = (m_axis_tvalid && !m_axis_tready) ? m_axis_tuser : (tlast_d && err_arm_d);
`else
    tuser_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0; rem_q <= '0; gap_q <= '0; num_q <= '0;
      seq_q <= '0; beat_q <= '0; gap_cnt_q <= '0; pkt_cnt <= '0;
      m_axis_tdata <= '0; m_axis_tvalid <= 1'b0; m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0; m_axis_tuser <= 1'b0; busy <= 1'b0;
`ifdef FHG_PKT_GEN_ERR_INJ_EN
      err_arm_q <= 1'b0;
`endif
    end else begin
      beats_q <= beats_d; rem_q <= rem_d; gap_q <= gap_d; num_q <= num_d;
      seq_q <= seq_d; beat_q <= beat_d; gap_cnt_q <= gap_cnt_d; pkt_cnt <= cnt_d;
      m_axis_tdata <= tdata_d; m_axis_tvalid <= tvalid_d; m_axis_tkeep <= tkeep_d;
      m_axis_tlast <= tlast_d; m_axis_tuser <= tuser_d; busy <= busy_d;
`ifdef FHG_PKT_GEN_ERR_INJ_EN
      err_arm_q <= err_arm_d;
`endif
    end
  end
endmodule

// File: tb/tb_fhg_axis_pkt_gen.sv
// Directed bench for fhg_axis_pkt_gen: expected-beat queue built from packet rules,
// checked on every handshake, plus stall stability, gap length and literal spot checks.
module tb_fhg_axis_pkt_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [15:0] cfg_pkt_bytes = '0;
  logic [7:0]  cfg_gap = '0;
  logic [31:0] cfg_num_pkts = '0;
  logic [1023:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy;
  logic m_axis_tready = 1'b1;
  logic [127:0] m_axis_tkeep;
  logic [31:0] pkt_cnt;
`ifdef FHG_PKT_GEN_ERR_INJ_EN
  logic err_inj = 1'b0;
`endif

  always #5 clk = ~clk;

  fhg_axis_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_pkt_bytes(cfg_pkt_bytes), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
`ifdef FHG_PKT_GEN_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [1023:0] d;
    logic [127:0]  k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t sb[$];
  int nvec = 0, nerr = 0;
  int hs_total = 0, tlast_total = 0, step_n = 0, tl_step = 0;
  int cap_idx = -1, keep_cap_idx = -1, user_cap_idx = -1;
  logic [63:0]  cap_lane;
  logic [127:0] cap_keep;
  logic         cap_user;
  bit chk_gap = 0, gap_act = 0;
  int exp_gap = 0, gap_cycles = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected beats derived straight from the length/keep/payload rules.
  task automatic push_pkts(input int len, input int first_seq, input int npkts, input int err_pkt);
    int L, B, r;
    beat_t e;
    L = (len < 64) ? 64 : (len > 9600) ? 9600 : len;
    B = (L + 127) / 128;
    r = L % 128;
    for (int p = 0; p < npkts; p++)
      for (int b = 0; b < B; b++) begin
        for (int k = 0; k < 16; k++) e.d[64*k +: 64] = {32'(first_seq + p), 16'(b), 16'(k)};
        for (int i = 0; i < 128; i++) e.k[i] = (b < B - 1) || (r == 0) || (i < r);
        e.l = (b == B - 1);
        e.u = (b == B - 1) && (p == err_pkt);
        sb.push_back(e);
      end
  endtask

  // Inputs must be set before calling; checks the handshake about to happen, then advances one cycle.
  task automatic step();
    beat_t e;
    bit hs, hs_last, stall;
    logic [1023:0] hd;
    logic [127:0] hk;
    logic hl, hu;
    int ln;
    hs      = m_axis_tvalid && m_axis_tready && !rst;
    hs_last = hs && m_axis_tlast;
    if (hs) begin
      if (hs_total == cap_idx)      cap_lane = m_axis_tdata[3*64 +: 64];
      if (hs_total == keep_cap_idx) cap_keep = m_axis_tkeep;
      if (hs_total == user_cap_idx) cap_user = m_axis_tuser;
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL beat %0d: unexpected beat, none outstanding", hs_total);
      end else begin
        e = sb.pop_front();
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== e) begin
          nerr++;
          ln = 0;
          for (int k = 15; k >= 0; k--) if (m_axis_tdata[64*k +: 64] !== e.d[64*k +: 64]) ln = k;
          $display("FAIL beat %0d: lane%0d %h want %h, keep %h want %h, last %b want %b, user %b want %b",
                   hs_total, ln, m_axis_tdata[64*ln +: 64], e.d[64*ln +: 64], m_axis_tkeep, e.k,
                   m_axis_tlast, e.l, m_axis_tuser, e.u);
        end
      end
      hs_total++;
      if (hs_last) begin tlast_total++; tl_step = step_n + 1; end
    end
    stall = m_axis_tvalid && !m_axis_tready && !rst;
    hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast; hu = m_axis_tuser;
    @(negedge clk);
    step_n++;
    if (stall && !rst) begin
      nvec++;
      if (!m_axis_tvalid || {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== {hd, hk, hl, hu}) begin
        nerr++;
        $display("FAIL stall_hold beat %0d: tvalid %b keep %h want %h last %b want %b",
                 hs_total, m_axis_tvalid, m_axis_tkeep, hk, m_axis_tlast, hl);
      end
    end
    if (hs_last) begin gap_act = 1; gap_cycles = 0; end
    if (gap_act) begin
      if (!busy) gap_act = 0;
      else if (!m_axis_tvalid) gap_cycles++;
      else begin
        if (chk_gap) chk("gap_len", 128'(gap_cycles), 128'(exp_gap));
        gap_act = 0;
      end
    end
  endtask

  task automatic kick(input int len, input int gap, input int num);
    cfg_pkt_bytes = 16'(len); cfg_gap = 8'(gap); cfg_num_pkts = 32'(num);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (busy && n < max) begin step(); n++; end
    chk(nm, 128'(busy), 128'(0));
  endtask

  initial begin
    int base, n, errp;
    logic [127:0] keep72, keep64;
    keep72 = {56'd0, {72{1'b1}}};
    keep64 = {64'd0, {64{1'b1}}};
`ifdef FHG_PKT_GEN_ERR_INJ_EN
    errp = 1;
`else
    errp = -1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tdata",  128'(m_axis_tdata !== '0), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tkeep",  m_axis_tkeep, 128'(0));
    chk("rst_tlast",  128'(m_axis_tlast), 128'(0));
    chk("rst_tuser",  128'(m_axis_tuser), 128'(0));
    chk("rst_busy",   128'(busy), 128'(0));
    chk("rst_pktcnt", 128'(pkt_cnt), 128'(0));
    rst = 1'b0;
    step();

    // 8192 B x2, back-to-back
    push_pkts(8192, 0, 2, -1);
    chk_gap = 1; exp_gap = 0;
    base = hs_total; cap_idx = base + 64; n = tlast_total;
    kick(8192, 0, 2);
    chk("t1_lat_tvalid", 128'(m_axis_tvalid), 128'(1));
    chk("t1_lat_busy",   128'(busy), 128'(1));
    wait_idle(400, "t1_timeout");
    chk("t1_pkt_cnt",  128'(pkt_cnt), 128'(2));
    chk("t1_b64_lane3", 128'(cap_lane), 128'(64'h0000_0001_0000_0003));
    chk("t1_tlasts",   128'(tlast_total - n), 128'(2));
    chk("t1_beats",    128'(hs_total - base), 128'(128));
    chk("t1_sb_empty", 128'(sb.size()), 128'(0));

    // 200 B, gap 2, x3
    push_pkts(200, 0, 3, -1);
    exp_gap = 2; keep_cap_idx = hs_total + 1;
    kick(200, 2, 3);
    wait_idle(100, "t2_timeout");
    chk("t2_pkt_cnt",   128'(pkt_cnt), 128'(3));
    chk("t2_last_keep", cap_keep, keep72);
    chk("t2_sb_empty",  128'(sb.size()), 128'(0));

    // 20 B clamps to 64
    push_pkts(20, 0, 1, -1);
    keep_cap_idx = hs_total;
    kick(20, 0, 1);
    wait_idle(20, "t3_timeout");
    chk("t3_keep",    cap_keep, keep64);
    chk("t3_pkt_cnt", 128'(pkt_cnt), 128'(1));

    // backpressure: alternating ready plus a 10-cycle stall
    push_pkts(8192, 0, 1, -1);
    chk_gap = 0; base = hs_total;
    kick(8192, 0, 1);
    for (int i = 0; i < 400 && busy; i++) begin
      m_axis_tready = (i >= 20 && i < 30) ? 1'b0 : (i % 2 == 0);
      step();
    end
    m_axis_tready = 1'b1;
    chk("t4_timeout",  128'(busy), 128'(0));
    chk("t4_beats",    128'(hs_total - base), 128'(64));
    chk("t4_sb_empty", 128'(sb.size()), 128'(0));

    // unlimited run, stop during packet 5 beat 30
    push_pkts(8192, 0, 6, -1);
    chk_gap = 1; exp_gap = 0; base = hs_total; n = 0;
    kick(8192, 0, 0);
    while (busy && n < 1000) begin
      if (hs_total - base >= 5 * 64 + 30) stop = 1'b1;
      step(); n++;
    end
    stop = 1'b0;
    chk("t5_timeout",     128'(busy), 128'(0));
    chk("t5_pkt_cnt",     128'(pkt_cnt), 128'(6));
    chk("t5_idle_next",   128'(step_n - tl_step), 128'(0));
    chk("t5_sb_empty",    128'(sb.size()), 128'(0));

    // reset mid-packet, then a fresh run
    push_pkts(8192, 0, 1, -1);
    base = hs_total; n = 0;
    kick(8192, 0, 0);
    while (hs_total - base < 10 && n < 100) begin step(); n++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("t6_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("t6_rst_tlast",  128'(m_axis_tlast), 128'(0));
    chk("t6_rst_busy",   128'(busy), 128'(0));
    chk("t6_rst_cnt",    128'(pkt_cnt), 128'(0));
    push_pkts(200, 0, 2, errp);
    exp_gap = 1; base = hs_total; user_cap_idx = base + 3; n = 0;
    kick(200, 1, 2);
    while (busy && n < 100) begin
`ifdef FHG_PKT_GEN_ERR_INJ_EN
      err_inj = m_axis_tvalid && m_axis_tlast && (hs_total - base == 1);
`endif
      step(); n++;
`ifdef FHG_PKT_GEN_ERR_INJ_EN
      err_inj = 1'b0;
`endif
    end
    chk("t6_timeout",  128'(busy), 128'(0));
    chk("t6_pkt_cnt",  128'(pkt_cnt), 128'(2));
    chk("t6_p1_tuser", 128'(cap_user), 128'(errp == 1));
    chk("t6_sb_empty", 128'(sb.size()), 128'(0));

    // start and stop together in IDLE: stop wins
    cfg_num_pkts = 32'd1; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("t7_busy",   128'(busy), 128'(0));
    chk("t7_tvalid", 128'(m_axis_tvalid), 128'(0));
    step();
    chk("t7_busy2",  128'(busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
